// File: rtl/rr_sel_arbiter_4_if.sv
// Request/grant bus between four requesters, the 4:1 mux stage and the
// round-robin select arbiter. Optional burst-lock input under RR_ARB_LOCK_EN.
interface rr_sel_arbiter_4_if;
  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  logic [N_CH-1:0]  req;
  logic             ready;
  logic [SEL_W-1:0] sel;
  logic [N_CH-1:0]  grant;
  logic             valid;
`ifdef RR_ARB_LOCK_EN
  logic             lock;

  modport master (input req, ready, lock, output sel, grant, valid);
  modport slave  (output req, ready, lock, input sel, grant, valid);
`else
  modport master (input req, ready, output sel, grant, valid);
  modport slave  (output req, ready, input sel, grant, valid);
`endif
endinterface

// File: rtl/rr_sel_arbiter_4.sv
// Four-channel round-robin arbiter producing a registered 4:1 mux select
// with a valid/ready handshake. Priority rotates past each served channel.
// Optional feature macro: RR_ARB_LOCK_EN (burst lock keeps the current
// channel granted while lock and its request stay high).
module rr_sel_arbiter_4 #(
  parameter int unsigned START_PTR = 0
) (
  input  logic               clk,
  input  logic               rst,
  rr_sel_arbiter_4_if.master bus
);
  localparam int unsigned N_CH  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  sel_q;
  logic [N_CH-1:0]   grant_q;
  logic              valid_q;

  logic              handshake;
  logic              lock_hit;
  logic [SEL_W-1:0]  arb_ptr;
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  win_idx;
  logic              win_found;

  assign handshake = (state == GRANT) && valid_q && bus.ready;

`ifdef RR_ARB_LOCK_EN
  assign lock_hit = bus.lock && bus.req[sel_q];
`else
  assign lock_hit = 1'b0;
`endif

  // Pick the search start: rotated (or locked) pointer on a handshake, else current.
  always_comb begin
    arb_ptr = ptr;
    if (handshake) begin
      arb_ptr = lock_hit ? sel_q : SEL_W'(sel_q + SEL_W'(1));
    end
  end

  // First requesting channel in order arb_ptr, arb_ptr+1, ... (mod 4).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = SEL_W'(arb_ptr + SEL_W'(k));
      if (bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Arbitration FSM with registered select, grant and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      grant_q <= '0;
      sel_q   <= '0;
      ptr     <= SEL_W'(START_PTR);
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            sel_q   <= win_idx;
            grant_q <= N_CH'(1) << win_idx;
            valid_q <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (bus.ready) begin
            ptr <= arb_ptr;
            if (win_found) begin
              sel_q   <= win_idx;
              grant_q <= N_CH'(1) << win_idx;
            end else begin
              valid_q <= 1'b0;
              grant_q <= '0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
endmodule
